lsu_mem: RTL and testbench

- Load/store unit sitting directly downstream of the ALU and upstream of register-file write-back.
- Takes the ALU effective address plus the store operand, then runs the single-port word RAM access (read, write, or read-modify-write for sub-word stores).
- For loads, returns the aligned, sign- or zero-extended result with a one-cycle write-back strobe.
- Multi-cycle FSM; only one access may be in flight at a time.

---
 rtl/lsu_mem.sv | 199 +++++++++++++++++++
 tb/tb_lsu_mem.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
// Load/store unit: sequences single-port word-RAM reads, writes and sub-word read-modify-writes.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete with err_o instead of being force-aligned.
module lsu_mem #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            we_o,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] data_o,
  input  logic [XLEN-1:0] data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] wd_o,
  output logic            wd_q_o,
  output logic            err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPTURE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

  state_t            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              legal;
  logic              go_err;
  logic [XLEN-1:0]   addr_al;
  logic [4:0]        shamt;
  logic [XLEN-1:0]   rsh;
  logic [XLEN-1:0]   ld_val;
  logic [XLEN-1:0]   mask;
  logic [XLEN-1:0]   merged;

  // Request decode, evaluated against the live inputs while idle.
  always_comb begin
    if (is_store_i) begin
      legal = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11);
    end else begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end

    addr_al = addr_i;
    if (funct3_i[1:0] == 2'b01) addr_al[0]   = 1'b0;
    if (funct3_i[1:0] == 2'b10) addr_al[1:0] = 2'b00;

`ifdef LSU_MISALIGN_TRAP_EN
    go_err = !legal
           || ((funct3_i[1:0] == 2'b01) && addr_i[0])
           || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    go_err = !legal;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    shamt = {addr_q[1:0], 3'b000};
    rsh   = rdata_q >> shamt;

    case (f3_q)
      3'b000:  ld_val = {{(XLEN-8){rsh[7]}}, rsh[7:0]};
      3'b001:  ld_val = {{(XLEN-16){rsh[15]}}, rsh[15:0]};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, rsh[7:0]};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, rsh[15:0]};
      default: ld_val = rdata_q;
    endcase

    if (f3_q[0]) mask = XLEN'(16'hFFFF) << shamt;
    else         mask = XLEN'(8'hFF) << shamt;
    merged = (rdata_q & ~mask) | ((data_q << shamt) & mask);
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    we_o       = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    wd_q_o     = 1'b0;
    err_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          is_store_d = is_store_i;
          f3_d       = funct3_i;
          if (go_err) begin
            state_d = S_ERR;
          end else begin
            addr_d = addr_al;
            if (is_store_i) data_d = store_data_i;
            if (is_store_i && (funct3_i[1:0] == 2'b10)) state_d = S_WRITE;
            else                                        state_d = S_READ;
          end
        end
      end
      S_READ: begin
        cnt_d   = LAT_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = data_i;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_CAPTURE: begin
        if (is_store_q) begin
          data_d  = merged;
          state_d = S_WRITE;
        end else begin
          wdata_d = ld_val;
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        we_o    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        wd_q_o  = !is_store_q;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done_o  = 1'b1;
        err_o   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_store_q <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      is_store_q <= is_store_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign addr_o = {addr_q[XLEN-1:2], 2'b00};
  assign data_o = data_q;
  assign wd_o   = wdata_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: one instance with RAM_LAT=1 and one with RAM_LAT=3, each with a small RAM model.
module tb_lsu_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3, isst;
  logic [2:0]  f3;
  logic [31:0] a, sd;

  logic        we1, busy1, done1, wdq1, err1;
  logic [31:0] addr1, dout1, din1, wd1;
  logic        we3, busy3, done3, wdq3, err3;
  logic [31:0] addr3, dout3, din3, wd3;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p3a, p3b;
  int          wc1 = 0;
  int          wc3 = 0;
  logic        pre_we = 1'b0;
  logic        pre_sel = 1'b0;
  logic [31:0] pre_a = '0;
  logic [31:0] pre_d = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem #(.XLEN(32), .RAM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start_i(start1), .is_store_i(isst), .funct3_i(f3),
    .addr_i(a), .store_data_i(sd), .we_o(we1), .addr_o(addr1), .data_o(dout1),
    .data_i(din1), .busy_o(busy1), .done_o(done1), .wd_o(wd1), .wd_q_o(wdq1), .err_o(err1)
  );

  lsu_mem #(.XLEN(32), .RAM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start_i(start3), .is_store_i(isst), .funct3_i(f3),
    .addr_i(a), .store_data_i(sd), .we_o(we3), .addr_o(addr3), .data_o(dout3),
    .data_i(din3), .busy_o(busy3), .done_o(done3), .wd_o(wd3), .wd_q_o(wdq3), .err_o(err3)
  );

  always @(posedge clk) begin
    if (pre_we && !pre_sel) mem1[pre_a[9:2]] <= pre_d;
    else if (we1)           mem1[addr1[9:2]] <= dout1;
    din1 <= mem1[addr1[9:2]];
    if (we1) wc1 <= wc1 + 1;
  end

  always @(posedge clk) begin
    if (pre_we && pre_sel) mem3[pre_a[9:2]] <= pre_d;
    else if (we3)          mem3[addr3[9:2]] <= dout3;
    p3a  <= mem3[addr3[9:2]];
    p3b  <= p3a;
    din3 <= p3b;
    if (we3) wc3 <= wc3 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit s3, input logic [31:0] ad, input logic [31:0] d);
    pre_sel = s3; pre_a = ad; pre_d = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Pulses start in cycle 0 and reports the cycle index of done_o (-1 if it never came).
  task automatic access(input bit s3, input bit store, input logic [2:0] fn,
                        input logic [31:0] ad, input logic [31:0] d,
                        output int lat, output logic wq, output logic er,
                        output int writes, output logic tail);
    int w0;
    isst = store; f3 = fn; a = ad; sd = d;
    w0 = s3 ? wc3 : wc1;
    if (s3) start3 = 1'b1; else start1 = 1'b1;
    lat = -1; wq = 1'b0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0; start3 = 1'b0;
      if ((s3 ? done3 : done1) === 1'b1) begin
        lat = c;
        wq  = s3 ? wdq3 : wdq1;
        er  = s3 ? err3 : err1;
        break;
      end
    end
    writes = (s3 ? wc3 : wc1) - w0;
    @(posedge clk); #1;
    tail = s3 ? (done3 | busy3) : (done1 | busy1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, wr, c, extra;
    logic        wq, er, tl;
    logic [31:0] wd_exp;

    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; isst = 1'b0; f3 = '0; a = '0; sd = '0;
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    {31'b0, we1},   32'h0);
    chk("rst_busy",  {31'b0, busy1}, 32'h0);
    chk("rst_done",  {31'b0, done1}, 32'h0);
    chk("rst_err",   {31'b0, err1},  32'h0);
    chk("rst_wdq",   {31'b0, wdq1},  32'h0);
    chk("rst_addr",  addr1, 32'h0);
    chk("rst_data",  dout1, 32'h0);
    chk("rst_wd",    wd1,   32'h0);
    chk("rst_busy3", {31'b0, busy3}, 32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    preload(1'b0, 32'h100, 32'hDEADBEEF);
    access(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, lat, wq, er, wr, tl);
    chk("lw_lat",    32'(lat), 32'd4);
    chk("lw_wdq",    {31'b0, wq}, 32'h1);
    chk("lw_err",    {31'b0, er}, 32'h0);
    chk("lw_writes", 32'(wr), 32'd0);
    chk("lw_wd",     wd1, 32'hDEADBEEF);
    chk("lw_tail",   {31'b0, tl}, 32'h0);

    preload(1'b0, 32'h100, 32'h1234F678);
    access(1'b0, 1'b0, 3'b000, 32'h101, 32'h0, lat, wq, er, wr, tl);
    chk("lb_wd",  wd1, 32'hFFFFFFF6);
    chk("lb_lat", 32'(lat), 32'd4);
    access(1'b0, 1'b0, 3'b100, 32'h101, 32'h0, lat, wq, er, wr, tl);
    chk("lbu_wd", wd1, 32'h000000F6);
    access(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, lat, wq, er, wr, tl);
    chk("lh_hi_wd", wd1, 32'h00001234);
    access(1'b0, 1'b0, 3'b001, 32'h100, 32'h0, lat, wq, er, wr, tl);
    chk("lh_lo_wd", wd1, 32'hFFFFF678);
    access(1'b0, 1'b0, 3'b101, 32'h100, 32'h0, lat, wq, er, wr, tl);
    chk("lhu_wd", wd1, 32'h0000F678);
    wd_exp = 32'h0000F678;

    preload(1'b0, 32'h200, 32'h11223344);
    access(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000AA, lat, wq, er, wr, tl);
    chk("sb_lat",    32'(lat), 32'd5);
    chk("sb_wdq",    {31'b0, wq}, 32'h0);
    chk("sb_writes", 32'(wr), 32'd1);
    chk("sb_addr",   addr1, 32'h200);
    chk("sb_data",   dout1, 32'hAA223344);
    chk("sb_mem",    mem1[8'h80], 32'hAA223344);
    chk("sb_wd_keep", wd1, wd_exp);

    access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234BEEF, lat, wq, er, wr, tl);
    chk("sh_lat", 32'(lat), 32'd5);
    chk("sh_mem", mem1[8'h80], 32'hBEEF3344);

    access(1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, lat, wq, er, wr, tl);
    chk("sw_lat",    32'(lat), 32'd2);
    chk("sw_writes", 32'(wr), 32'd1);
    chk("sw_mem",    mem1[8'h81], 32'hCAFEF00D);

    preload(1'b0, 32'h300, 32'h8765C321);
    access(1'b0, 1'b0, 3'b001, 32'h301, 32'h0, lat, wq, er, wr, tl);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", {31'b0, er}, 32'h1);
    chk("mis_wdq", {31'b0, wq}, 32'h0);
`else
    chk("mis_lat", 32'(lat), 32'd4);
    chk("mis_err", {31'b0, er}, 32'h0);
    chk("mis_wdq", {31'b0, wq}, 32'h1);
    wd_exp = 32'hFFFFC321;
`endif
    chk("mis_writes", 32'(wr), 32'd0);
    chk("mis_wd", wd1, wd_exp);

    access(1'b0, 1'b0, 3'b011, 32'h100, 32'h0, lat, wq, er, wr, tl);
    chk("ill_ld_lat",    32'(lat), 32'd1);
    chk("ill_ld_err",    {31'b0, er}, 32'h1);
    chk("ill_ld_wdq",    {31'b0, wq}, 32'h0);
    chk("ill_ld_writes", 32'(wr), 32'd0);
    chk("ill_ld_wd",     wd1, wd_exp);
    chk("ill_ld_tail",   {31'b0, tl}, 32'h0);

    access(1'b0, 1'b1, 3'b100, 32'h204, 32'h0, lat, wq, er, wr, tl);
    chk("ill_st_lat",    32'(lat), 32'd1);
    chk("ill_st_err",    {31'b0, er}, 32'h1);
    chk("ill_st_writes", 32'(wr), 32'd0);
    chk("ill_st_mem",    mem1[8'h81], 32'hCAFEF00D);

    // RAM_LAT=3 instance: start re-pulsed during WAIT must be ignored.
    preload(1'b1, 32'h400, 32'h0BADF00D);
    preload(1'b1, 32'h404, 32'h13579BDF);
    isst = 1'b0; f3 = 3'b010; a = 32'h400; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    @(posedge clk); #1; a = 32'h404; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    c = 3;
    while (c <= 20 && done3 !== 1'b1) begin
      @(posedge clk); #1;
      c++;
    end
    lat = (done3 === 1'b1) ? c : -1;
    chk("rep_lat", 32'(lat), 32'd6);
    chk("rep_wd",  wd3, 32'h0BADF00D);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done3 === 1'b1 || busy3 === 1'b1) extra++;
    end
    chk("rep_ignored", 32'(extra), 32'd0);

    access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, lat, wq, er, wr, tl);
    chk("lw3_lat", 32'(lat), 32'd6);
    chk("lw3_wd",  wd3, 32'h13579BDF);

    preload(1'b1, 32'h408, 32'h00000080);
    access(1'b1, 1'b0, 3'b000, 32'h408, 32'h0, lat, wq, er, wr, tl);
    chk("lb3_wd", wd3, 32'hFFFFFF80);
    access(1'b1, 1'b1, 3'b000, 32'h409, 32'h0000005A, lat, wq, er, wr, tl);
    chk("sb3_lat", 32'(lat), 32'd7);
    chk("sb3_mem", mem3[8'h02], 32'h00005A80);

    // Reset asserted during the WRITE cycle of a store word.
    preload(1'b0, 32'h040, 32'h55555555);
    isst = 1'b1; f3 = 3'b010; a = 32'h040; sd = 32'h99999999; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    chk("rmw_in_write", {31'b0, we1}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rmw_we",   {31'b0, we1},   32'h0);
    chk("rmw_busy", {31'b0, busy1}, 32'h0);
    chk("rmw_data", dout1, 32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rmw_mem",  mem1[8'h10], 32'h55555555);
    chk("rmw_wd",   wd1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
